// File: rtl/audio_pkg.sv
// Shared audio-path types and helpers: sample width default, detector state, saturating rectifier.
// Pure declarations; no logic of its own.
package audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 24;
  localparam int MAX_SAMPLE_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    PUBLISH
  } state_t;

  // |x| of a width-bit two's-complement value held in the low bits of x;
  // the most negative code saturates to the largest positive one.
  function automatic logic [MAX_SAMPLE_WIDTH-1:0] abs_sat_fn(
    input logic [MAX_SAMPLE_WIDTH-1:0] x,
    input int                          width
  );
    logic [MAX_SAMPLE_WIDTH:0]   mask_ext;
    logic [MAX_SAMPLE_WIDTH-1:0] mask;
    logic [MAX_SAMPLE_WIDTH-1:0] max_pos;
    logic [MAX_SAMPLE_WIDTH-1:0] min_neg;
    logic [MAX_SAMPLE_WIDTH-1:0] v;
    mask_ext = ((MAX_SAMPLE_WIDTH+1)'(1) << width) - (MAX_SAMPLE_WIDTH+1)'(1);
    mask     = mask_ext[MAX_SAMPLE_WIDTH-1:0];
    max_pos  = mask_ext[MAX_SAMPLE_WIDTH:1];
    min_neg  = max_pos + MAX_SAMPLE_WIDTH'(1);
    v        = x & mask;
    if (v == min_neg)
      return max_pos;
    else if ((v & min_neg) != '0)
      return (~v + MAX_SAMPLE_WIDTH'(1)) & mask;
    else
      return v;
  endfunction

endpackage

// File: rtl/abs_sat.sv
// Combinational saturating full-wave rectifier, zero latency.
// No handshake: output follows input every cycle.
module abs_sat
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
) (
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [SAMPLE_WIDTH-1:0] mag
);

  assign mag = SAMPLE_WIDTH'(abs_sat_fn(MAX_SAMPLE_WIDTH'(sample), SAMPLE_WIDTH));

endmodule

// File: rtl/envelope_averager.sv
// Rectify-and-average envelope detector with optional one-pole smoothing; env_avg updates two cycles after the window-end sample.
// No backpressure: a sample is taken every cycle it is valid and enabled, including the publish cycle.
module envelope_averager
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH,
  parameter int WINDOW_LOG2  = 6,
  parameter int SMOOTH_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    enable,
  input  logic                    clear,
  output logic [SAMPLE_WIDTH-1:0] env_avg,
  output logic                    env_valid
);

  localparam int ACC_W = SAMPLE_WIDTH + WINDOW_LOG2;

  state_t                   state_q, state_d;
  logic [ACC_W-1:0]         acc_q;
  logic [WINDOW_LOG2-1:0]   cnt_q;
  logic [SAMPLE_WIDTH-1:0]  mag;
  logic [SAMPLE_WIDTH-1:0]  blk;
  logic [SAMPLE_WIDTH-1:0]  env_next;
  logic signed [SAMPLE_WIDTH:0] diff, step, env_next_ext;
  logic                     accept;
  logic                     window_end;

  abs_sat #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_abs_sat (
    .sample (sample_in),
    .mag    (mag)
  );

  assign accept     = sample_valid & enable & ~clear;
  assign window_end = accept & (state_q == ACCUM) & (cnt_q == '1);

  // acc cannot overflow, so the block average is simply its upper SAMPLE_WIDTH bits.
  assign blk          = acc_q[ACC_W-1:WINDOW_LOG2];
  assign diff         = $signed({1'b0, blk}) - $signed({1'b0, env_avg});
  assign step         = diff >>> SMOOTH_SHIFT;
  assign env_next_ext = $signed({1'b0, env_avg}) + step;
  assign env_next     = SAMPLE_WIDTH'(env_next_ext);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        IDLE:    state_d = ACCUM;
        ACCUM:   if (window_end) state_d = PUBLISH;
        PUBLISH: state_d = ACCUM;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      env_avg   <= '0;
      env_valid <= 1'b0;
    end else if (clear) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      env_avg   <= '0;
      env_valid <= 1'b0;
    end else if (!enable) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      env_valid <= 1'b0;
    end else begin
      env_valid <= (state_q == PUBLISH);
      if (state_q == PUBLISH) begin
        env_avg <= env_next;
        // A sample arriving while publishing opens the next window.
        acc_q   <= accept ? ACC_W'(mag) : '0;
        cnt_q   <= accept ? WINDOW_LOG2'(1) : '0;
      end else if (accept) begin
        acc_q <= acc_q + ACC_W'(mag);
        cnt_q <= cnt_q + WINDOW_LOG2'(1);
      end
    end
  end

endmodule

// File: tb/tb_envelope_averager.sv
// Directed bench: instance a (no smoothing) and instance b (SMOOTH_SHIFT=2) share the sample stream.
// Expected publishes are queued at issue time and matched by a negedge monitor.
module tb_envelope_averager;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic        enable_a, enable_b;
  logic        clear_a, clear_b;
  logic [23:0] env_avg_a, env_avg_b;
  logic        env_valid_a, env_valid_b;

  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  exp_t  q_a[$];
  exp_t  q_b[$];
  exp_t  ea, eb;
  logic [23:0] prev_a = '0, prev_b = '0;
  logic  clr_prev_a = 1'b0;
  logic  probe_req = 1'b0;
  logic  final_req = 1'b0;
  string probe_name = "";
  int    k1, k2;

  envelope_averager #(.SAMPLE_WIDTH(24), .WINDOW_LOG2(2), .SMOOTH_SHIFT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .enable(enable_a), .clear(clear_a), .env_avg(env_avg_a), .env_valid(env_valid_a)
  );

  envelope_averager #(.SAMPLE_WIDTH(24), .WINDOW_LOG2(2), .SMOOTH_SHIFT(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .enable(enable_b), .clear(clear_b), .env_avg(env_avg_b), .env_valid(env_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic check_eq(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Monitor: all comparisons happen here, on the falling edge.
  always @(negedge clk) begin
    if (env_valid_a) begin
      if (q_a.size() == 0) check_eq("a_unexpected_pulse", int'(env_avg_a), -1);
      else begin
        ea = q_a.pop_front();
        check_eq("a_env_avg", int'(env_avg_a), ea.val);
        check_eq("a_pulse_cycle", cyc, ea.cyc);
      end
    end
    if (env_valid_b) begin
      if (q_b.size() == 0) check_eq("b_unexpected_pulse", int'(env_avg_b), -1);
      else begin
        eb = q_b.pop_front();
        check_eq("b_env_avg", int'(env_avg_b), eb.val);
        check_eq("b_pulse_cycle", cyc, eb.cyc);
      end
    end
    if (env_avg_a != prev_a && !env_valid_a && !clr_prev_a && rst_n)
      check_eq("a_env_avg_held", int'(env_avg_a), int'(prev_a));
    if (env_avg_b != prev_b && !env_valid_b && rst_n)
      check_eq("b_env_avg_held", int'(env_avg_b), int'(prev_b));
    if (probe_req) begin
      check_eq(probe_name, int'(env_avg_a), 0);
      check_eq({probe_name, "_valid"}, int'(env_valid_a), 0);
    end
    if (final_req) begin
      check_eq("a_pending_publishes", q_a.size(), 0);
      check_eq("b_pending_publishes", q_b.size(), 0);
    end
    prev_a     = env_avg_a;
    prev_b     = env_avg_b;
    clr_prev_a = clear_a;
  end

  task automatic send(input int v);
    @(posedge clk); #1;
    sample_in    = v[23:0];
    sample_valid = 1'b1;
  endtask

  task automatic send_n(input int v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sample_valid = 1'b0;
    end
  endtask

  task automatic probe(input string name);
    probe_name = name;
    probe_req  = 1'b1;
    @(negedge clk); #1;
    probe_req  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0;
    enable_a = 1'b0; enable_b = 1'b0; clear_a = 1'b0; clear_b = 1'b0;
    repeat (2) @(posedge clk);
    probe("reset_init");
    @(posedge clk); #1;
    rst_n = 1'b1; enable_a = 1'b1;
    idle(1);

    // Basic average: 100,-200,300,-400 -> 250, pulse at k+2
    send(100); send(-200); send(300); send(-400);
    q_a.push_back('{250, cyc + 2});
    idle(4);

    // Reset mid-window discards the partial 1000,1000
    send(1000); send(1000);
    @(posedge clk); #1;
    sample_valid = 1'b0;
    #2 rst_n = 1'b0;
    probe("reset_mid_window");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_n(8, 4);
    q_a.push_back('{8, cyc + 2});
    idle(4);

    // Saturation of the most negative code
    send_n(-8388608, 4);
    q_a.push_back('{8388607, cyc + 2});
    idle(4);

    // Continuous stream, publish cycle carries the first sample of window 2
    send_n(40, 4);
    q_a.push_back('{40, cyc + 2});
    send_n(80, 4);
    q_a.push_back('{80, cyc + 2});
    idle(4);

    // Enable drop discards the partial window of 500s
    send_n(500, 3);
    @(posedge clk); #1;
    sample_valid = 1'b0; enable_a = 1'b0;
    idle(1);
    @(posedge clk); #1;
    enable_a = 1'b1;
    idle(1);
    send_n(12, 4);
    q_a.push_back('{12, cyc + 2});
    idle(4);

    // Clear on the 4th sample: no pulse, env_avg to 0, next window clean
    send_n(50, 3);
    @(posedge clk); #1;
    sample_in = 24'd50; sample_valid = 1'b1; clear_a = 1'b1;
    @(posedge clk); #1;
    clear_a = 1'b0; sample_valid = 1'b0;
    idle(2);
    probe("clear_env");
    send_n(20, 4);
    q_a.push_back('{20, cyc + 2});
    idle(4);

    // Smoothing on b from 0: 1000 windows -> 250 then 437
    @(posedge clk); #1;
    enable_b = 1'b1; sample_valid = 1'b0;
    idle(1);
    send_n(1000, 4);
    k1 = cyc;
    q_a.push_back('{1000, k1 + 2});
    q_b.push_back('{250, k1 + 2});
    send_n(1000, 4);
    k2 = cyc;
    q_a.push_back('{1000, k2 + 2});
    q_b.push_back('{437, k2 + 2});
    idle(6);

    final_req = 1'b1;
    @(negedge clk); #1;
    final_req = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/envelope_averager.md
# envelope_averager

Envelope detector stage directly upstream of `cutoff_freq_unit`. It full-wave rectifies the incoming signed audio samples and averages them over fixed power-of-two windows. An optional one-pole smoother is then applied, and the result is published as the registered, unsigned `env_avg` that `cutoff_freq_unit` consumes combinationally. `env_avg` is held stable between updates. A one-cycle `env_valid` pulse marks each update.

## Interface
- `SAMPLE_WIDTH`, 24: sample and envelope width, in bits.
- `WINDOW_LOG2`, 6: each window is 2^WINDOW_LOG2 accepted samples. Legal range is 1..12.
- `SMOOTH_SHIFT`, 0: smoothing coefficient is 2^-SMOOTH_SHIFT. A value of 0 means the block average is published directly. Legal range is 0..8.

Ports (clock and reset first):
- `clk` in 1: the single clock. All state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_in` in SAMPLE_WIDTH: signed two's-complement audio sample.
- `sample_valid` in 1: `sample_in` is valid this cycle.
- `enable` in 1: when low, the detector idles and `env_avg` is held.
- `clear` in 1: synchronous clear of the window and of `env_avg`.
- `env_avg` out SAMPLE_WIDTH: unsigned envelope, range 0..2^(SAMPLE_WIDTH-1)-1. Registered.
- `env_valid` out 1: one-cycle pulse, high in the first cycle a new `env_avg` is visible.

## Operation
- A sample is accepted when `sample_valid & enable & ~clear`.
- Rectification: `mag = |sample_in|`, saturating. The most negative value -2^(SAMPLE_WIDTH-1) maps to 2^(SAMPLE_WIDTH-1)-1.
- Accumulator `acc` is unsigned, SAMPLE_WIDTH+WINDOW_LOG2 bits, and cannot overflow.
- Sample counter `cnt` is WINDOW_LOG2 bits.
- State machine (state_t):
  - IDLE: `acc=0`, `cnt=0`. Moves to ACCUM when `enable=1`.
  - ACCUM: on each accepted sample, `acc+=mag` and `cnt+=1`. When the accepted sample is number 2^WINDOW_LOG2 (`cnt` wraps to 0), moves to PUBLISH.
  - PUBLISH (one cycle): computes `blk = acc >> WINDOW_LOG2`, then:
    - `diff = blk - env_avg`, signed, SAMPLE_WIDTH+1 bits.
    - `env_avg <= env_avg + (diff >>> SMOOTH_SHIFT)`, arithmetic shift, floor rounding.
    - Pulses `env_valid`, then returns to ACCUM.
    - A sample accepted during PUBLISH starts the next window: `acc <= mag`, `cnt <= 1`. No sample is ever dropped.
- Smoothing with floor rounding can settle up to 2^SMOOTH_SHIFT-1 below a rising target. It always reaches a falling target. This is accepted behaviour.
- `enable` low in any state:
  - Next state is IDLE.
  - `acc` and `cnt` are cleared; a partial window is discarded.
  - `env_avg` holds, and no `env_valid` pulse is generated.
- `clear=1` in any state:
  - `acc`, `cnt` and `env_avg` go to 0, `env_valid` goes to 0, and the state goes to ACCUM (or IDLE if `enable=0`).
  - `clear` has priority over sample acceptance and over a pending PUBLISH; the sample is dropped and no pulse occurs.
- Reset: state IDLE, `acc=0`, `cnt=0`, `env_avg=0`, `env_valid=0`. Reset asserted mid-window discards the window immediately, asynchronously.

## Timing
- Window-end sample presented in cycle k → PUBLISH in cycle k+1 → new `env_avg` visible and `env_valid=1` in cycle k+2 only.
- `env_avg` changes only on the edge that raises `env_valid`, or on `clear`/reset.
- Back-to-back samples every cycle are sustained indefinitely. Publish rate is one per 2^WINDOW_LOG2 accepted samples.
- No combinational path from inputs to outputs.

## Structure
- Shared package `audio_pkg` holds:
  - `SAMPLE_WIDTH` default constant.
  - `state_t` enum (IDLE, ACCUM, PUBLISH).
  - Saturating-abs function, also usable by other stages.
- One sub-module: `abs_sat`, the combinational saturating rectifier, parameterised by SAMPLE_WIDTH.
- Everything else lives in `envelope_averager`.

## Test plan
All scenarios use WINDOW_LOG2=2 unless noted.
- **Reset values:** assert `rst_n=0` mid-window, then release → `env_avg=0` and `env_valid=0` immediately. The next window of 8, 8, 8, 8 (SMOOTH_SHIFT=0) publishes 8.
- **Basic average:** SMOOTH_SHIFT=0, samples 100, -200, 300, -400 on consecutive cycles k-3..k → `env_valid=1` only in cycle k+2, `env_avg=250`.
- **Saturation:** four samples of -8388608 → `env_avg=8388607`.
- **Smoothing:** SMOOTH_SHIFT=2, `env_avg=0`, two consecutive windows of all 1000 → publishes 250, then 437.
- **Continuous stream:** samples every cycle including the PUBLISH cycle (window 1 is 4×40, window 2 is 4×80) → publishes 40 then 80, with pulses exactly 4 cycles apart and no sample lost.
- **Clear and enable:**
  - Drop `enable` after 3 samples, re-enable, then send 4×12 → publishes 12, not contaminated by the partial window.
  - `clear` coincident with the 4th sample → `env_avg=0`, no pulse.
